// File: rtl/pc_fetch_ctrl.sv
// Front-end fetch controller: owns the PC, issues one instruction-memory request
// at a time and hands fetched words to decode over a valid/ready handshake.
module pc_fetch_ctrl #(
  parameter int                XLEN         = 32,
  parameter logic [XLEN-1:0]   RESET_VECTOR = '0,
  parameter int                BOOT_DELAY   = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall_i,
  input  logic            redirect_valid_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rvalid_i,
  input  logic [XLEN-1:0] imem_rdata_i,
  output logic            if_valid_o,
  output logic [XLEN-1:0] if_pc_o,
  output logic [XLEN-1:0] if_instr_o,
  input  logic            if_ready_i,
  output logic [XLEN-1:0] pc_o
);

  localparam int CNT_W = (BOOT_DELAY < 2) ? 1 : $clog2(BOOT_DELAY + 1);

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [XLEN-1:0]   r_pc, w_pc_nxt;
  logic [XLEN-1:0]   r_req_pc, w_req_pc_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic              r_kill, w_kill_nxt;
  logic              r_if_valid, w_if_valid_nxt;
  logic [XLEN-1:0]   r_if_pc, w_if_pc_nxt;
  logic [XLEN-1:0]   r_if_instr, w_if_instr_nxt;
  logic              w_req;
  logic [XLEN-1:0]   w_tgt;
  logic              w_unused;

  assign w_tgt    = {redirect_pc_i[XLEN-1:2], 2'b00};
  assign w_unused = ^redirect_pc_i[1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_BOOT;
      r_pc       <= RESET_VECTOR;
      r_req_pc   <= '0;
      r_cnt      <= CNT_W'(BOOT_DELAY);
      r_kill     <= 1'b0;
      r_if_valid <= 1'b0;
      r_if_pc    <= '0;
      r_if_instr <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_req_pc   <= w_req_pc_nxt;
      r_cnt      <= w_cnt_nxt;
      r_kill     <= w_kill_nxt;
      r_if_valid <= w_if_valid_nxt;
      r_if_pc    <= w_if_pc_nxt;
      r_if_instr <= w_if_instr_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_req_pc_nxt   = r_req_pc;
    w_cnt_nxt      = r_cnt;
    w_kill_nxt     = r_kill;
    w_if_valid_nxt = r_if_valid;
    w_if_pc_nxt    = r_if_pc;
    w_if_instr_nxt = r_if_instr;
    w_req          = 1'b0;
    case (r_state)
      S_BOOT: begin
        if (redirect_valid_i) w_pc_nxt = w_tgt;
        if (r_cnt != '0) w_cnt_nxt = r_cnt - CNT_W'(1);
        // Leave on the edge that ends the last idle cycle, so BOOT_DELAY=2
        // gives exactly two idle cycles before the first request.
        if (r_cnt <= CNT_W'(1)) w_state_nxt = S_REQ;
      end
      S_REQ: begin
        w_req = ~stall_i & ~redirect_valid_i;
        if (redirect_valid_i) begin
          w_pc_nxt = w_tgt;
        end else if (w_req && imem_gnt_i) begin
          w_req_pc_nxt = r_pc;
          w_pc_nxt     = r_pc + XLEN'(4);
          w_state_nxt  = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_rvalid_i) begin
          if (r_kill || redirect_valid_i) begin
            w_kill_nxt  = 1'b0;
            if (redirect_valid_i) w_pc_nxt = w_tgt;
            w_state_nxt = S_REQ;
          end else begin
            w_if_valid_nxt = 1'b1;
            w_if_pc_nxt    = r_req_pc;
            w_if_instr_nxt = imem_rdata_i;
            w_state_nxt    = S_HOLD;
          end
        end else if (redirect_valid_i) begin
          w_pc_nxt   = w_tgt;
          w_kill_nxt = 1'b1;
        end
      end
      S_HOLD: begin
        if (redirect_valid_i) begin
          w_if_valid_nxt = 1'b0;
          w_pc_nxt       = w_tgt;
          w_state_nxt    = S_REQ;
        end else if (if_ready_i) begin
          w_if_valid_nxt = 1'b0;
          w_state_nxt    = S_REQ;
        end
      end
      default: w_state_nxt = S_BOOT;
    endcase
  end

  assign imem_req_o  = w_req;
  assign imem_addr_o = r_pc;
  assign pc_o        = r_pc;
  assign if_valid_o  = r_if_valid;
  assign if_pc_o     = r_if_pc;
  assign if_instr_o  = r_if_instr;

endmodule
